// File: rtl/csr_arbiter.sv
// Round-robin arbiter that lets NREQ requesters share one CSR port, one access in flight at a time.
// Optional ISSUE-phase watchdog is enabled by defining CSR_ARB_TIMEOUT_EN.
module csr_arbiter #(
  parameter int NREQ    = 2,
  parameter int TIMEOUT = 255
) (
  input  logic                 PCLK,
  input  logic                 PRESET,
  input  logic [NREQ-1:0]      req_valid,
  input  logic [NREQ-1:0]      req_write,
  input  logic [8*NREQ-1:0]    req_addr,
  input  logic [32*NREQ-1:0]   req_wdata,
  output logic [NREQ-1:0]      req_ready,
  output logic [NREQ-1:0]      rsp_valid,
  output logic [31:0]          rsp_rdata,
  output logic                 rsp_error,
  output logic                 csr_write,
  output logic                 csr_read,
  output logic [7:0]           csr_addr,
  output logic [31:0]          csr_wdata,
  input  logic [31:0]          csr_rdata,
  input  logic                 csr_ready,
  input  logic                 csr_error,
  output logic                 busy
);

  localparam int IW = $clog2(NREQ);

  if (NREQ < 2 || NREQ > 8) begin : g_bad_nreq
    $error("csr_arbiter: NREQ must be in 2..8");
  end
  if (TIMEOUT < 1 || TIMEOUT > 255) begin : g_bad_timeout
    $error("csr_arbiter: TIMEOUT must be in 1..255");
  end

  typedef enum logic [1:0] {IDLE, ISSUE, RESP} state_t;

  state_t        state;
  logic [IW-1:0] ptr;
  logic [IW-1:0] win;
  logic [IW-1:0] win_idx;
  logic [IW-1:0] ptr_next;
  logic          any_req;
  int            idx;

`ifdef CSR_ARB_TIMEOUT_EN
  localparam logic [7:0] TIMEOUT_LAST = 8'(TIMEOUT - 1);
  logic [7:0] issue_cnt;
`endif

  // Scan from the highest offset down so the requester closest to the pointer wins.
  always_comb begin
    any_req = 1'b0;
    win     = '0;
    idx     = 0;
    for (int k = NREQ - 1; k >= 0; k--) begin
      idx = (int'(ptr) + k) % NREQ;
      if (req_valid[idx]) begin
        any_req = 1'b1;
        win     = IW'(idx);
      end
    end
    ptr_next = (int'(win) == NREQ - 1) ? '0 : win + 1'b1;
  end

  always_comb begin
    req_ready = '0;
    if (state == IDLE && !PRESET && any_req) begin
      req_ready[win] = 1'b1;
    end
  end

  assign busy = (state != IDLE);

  always_ff @(posedge PCLK) begin
    if (PRESET) begin
      state     <= IDLE;
      ptr       <= '0;
      win_idx   <= '0;
      csr_write <= 1'b0;
      csr_read  <= 1'b0;
      csr_addr  <= '0;
      csr_wdata <= '0;
      rsp_valid <= '0;
      rsp_rdata <= '0;
      rsp_error <= 1'b0;
`ifdef CSR_ARB_TIMEOUT_EN
      issue_cnt <= '0;
`endif
    end else begin
      rsp_valid <= '0;
      case (state)
        IDLE: begin
          if (any_req) begin
            state     <= ISSUE;
            ptr       <= ptr_next;
            win_idx   <= win;
            csr_write <= req_write[win];
            csr_read  <= ~req_write[win];
            csr_addr  <= req_addr[8*int'(win) +: 8];
            csr_wdata <= req_wdata[32*int'(win) +: 32];
`ifdef CSR_ARB_TIMEOUT_EN
            issue_cnt <= '0;
`endif
          end
        end
        // A real csr_ready always beats an expiring watchdog in the same cycle.
        ISSUE: begin
          if (csr_ready) begin
            state              <= RESP;
            csr_write          <= 1'b0;
            csr_read           <= 1'b0;
            rsp_valid[win_idx] <= 1'b1;
            rsp_rdata          <= csr_write ? 32'd0 : csr_rdata;
            rsp_error          <= csr_error;
          end
`ifdef CSR_ARB_TIMEOUT_EN
          else if (issue_cnt == TIMEOUT_LAST) begin
            state              <= RESP;
            csr_write          <= 1'b0;
            csr_read           <= 1'b0;
            rsp_valid[win_idx] <= 1'b1;
            rsp_rdata          <= 32'd0;
            rsp_error          <= 1'b1;
          end else begin
            issue_cnt <= issue_cnt + 8'd1;
          end
`endif
        end
        RESP: begin
          state <= IDLE;
        end
        default: begin
          state <= IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_csr_arbiter.sv
// Scoreboard bench for csr_arbiter: directed requests push expected responses, a monitor pops them on rsp_valid.
// Build with CSR_ARB_TIMEOUT_EN defined to also cover the watchdog path (TIMEOUT=16).
module tb_csr_arbiter;

  logic        PCLK;
  logic        PRESET;
  logic [1:0]  req_valid;
  logic [1:0]  req_write;
  logic [15:0] req_addr;
  logic [63:0] req_wdata;
  logic [1:0]  req_ready;
  logic [1:0]  rsp_valid;
  logic [31:0] rsp_rdata;
  logic        rsp_error;
  logic        csr_write;
  logic        csr_read;
  logic [7:0]  csr_addr;
  logic [31:0] csr_wdata;
  logic [31:0] csr_rdata;
  logic        csr_ready;
  logic        csr_error;
  logic        busy;

  csr_arbiter #(.NREQ(2), .TIMEOUT(16)) dut (
    .PCLK(PCLK), .PRESET(PRESET),
    .req_valid(req_valid), .req_write(req_write), .req_addr(req_addr), .req_wdata(req_wdata),
    .req_ready(req_ready), .rsp_valid(rsp_valid), .rsp_rdata(rsp_rdata), .rsp_error(rsp_error),
    .csr_write(csr_write), .csr_read(csr_read), .csr_addr(csr_addr), .csr_wdata(csr_wdata),
    .csr_rdata(csr_rdata), .csr_ready(csr_ready), .csr_error(csr_error), .busy(busy)
  );

  typedef struct {
    logic [1:0]  valid;
    logic [31:0] rdata;
    logic        err;
    logic        wr;
    logic [7:0]  addr;
    logic [31:0] wdata;
    int          strobes;
    int          gap;
  } exp_t;

  exp_t        q[$];
  int          errors = 0;
  int          checks = 0;
  int          ready_delay = 1;
  logic [31:0] rdata_cfg = 32'h0;
  logic        err_cfg = 1'b0;

  initial begin
    PCLK = 1'b0;
    forever #5 PCLK = ~PCLK;
  end

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("[TB] FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
    end
  endtask

  task automatic expect_rsp(input logic [1:0] v, input logic [31:0] rd, input logic er, input logic wr,
                            input logic [7:0] a, input logic [31:0] wd, input int s, input int g);
    exp_t e;
    e.valid = v; e.rdata = rd; e.err = er; e.wr = wr;
    e.addr = a; e.wdata = wd; e.strobes = s; e.gap = g;
    q.push_back(e);
  endtask

  // CSR slave model: raises csr_ready on the ready_delay-th strobe cycle (0 = never).
  int rcnt = 0;
  initial begin
    csr_ready = 1'b0;
    csr_error = 1'b0;
    csr_rdata = 32'h0;
  end
  always @(posedge PCLK) begin
    #1;
    if (PRESET || !(csr_read || csr_write)) begin
      rcnt      = 0;
      csr_ready = 1'b0;
    end else begin
      rcnt++;
      csr_ready = (ready_delay != 0) && (rcnt >= ready_delay);
      csr_rdata = rdata_cfg;
      csr_error = err_cfg;
    end
  end

  // Monitor: tracks the strobe phase and checks every response against the scoreboard.
  int          cyc = 0;
  int          last_rsp = 0;
  int          strobe_cnt = 0;
  logic [7:0]  cap_addr = 8'h0;
  logic [31:0] cap_wdata = 32'h0;
  logic        cap_wr = 1'b0;
  always @(negedge PCLK) begin
    exp_t e;
    cyc++;
    if (PRESET) begin
      strobe_cnt = 0;
    end else begin
      if (csr_read || csr_write) begin
        if (strobe_cnt == 0) begin
          cap_addr  = csr_addr;
          cap_wdata = csr_wdata;
          cap_wr    = csr_write;
        end
        strobe_cnt++;
      end
      if (rsp_valid != 2'b00) begin
        if (q.size() == 0) begin
          chk("unexpected_rsp", {30'd0, rsp_valid}, 32'd0);
        end else begin
          e = q.pop_front();
          chk("rsp_valid", {30'd0, rsp_valid}, {30'd0, e.valid});
          chk("rsp_rdata", rsp_rdata, e.rdata);
          chk("rsp_error", {31'd0, rsp_error}, {31'd0, e.err});
          chk("csr_dir", {31'd0, cap_wr}, {31'd0, e.wr});
          chk("csr_addr", {24'd0, cap_addr}, {24'd0, e.addr});
          chk("strobe_cycles", strobe_cnt, e.strobes);
          if (e.wr) chk("csr_wdata", cap_wdata, e.wdata);
          if (e.gap > 0) chk("rsp_spacing", cyc - last_rsp, e.gap);
        end
        last_rsp   = cyc;
        strobe_cnt = 0;
      end
    end
  end

  task automatic applyStimulus(input int i, input logic w, input logic [7:0] a, input logic [31:0] d);
    int budget = 0;
    @(posedge PCLK); #1;
    req_valid[i] = 1'b1;
    req_write[i] = w;
    req_addr[8*i +: 8]   = a;
    req_wdata[32*i +: 32] = d;
    do begin
      @(negedge PCLK);
      budget++;
    end while (req_ready == 2'b00 && budget < 50);
    chk("issue_grant", {30'd0, req_ready}, 32'd1 << i);
    @(posedge PCLK); #1;
    req_valid[i] = 1'b0;
  endtask

  task automatic hold_both(input int n, input logic [1:0] first);
    int acc = 0;
    int budget = 0;
    @(posedge PCLK); #1;
    req_valid = 2'b11;
    req_write = 2'b00;
    req_addr  = {8'h21, 8'h10};
    while (acc < n && budget < 200) begin
      @(negedge PCLK);
      budget++;
      if (req_ready != 2'b00) begin
        if (acc == 0) chk("first_grant", {30'd0, req_ready}, {30'd0, first});
        acc++;
        if (acc == n) begin
          @(posedge PCLK); #1;
          req_valid = 2'b00;
        end
      end
    end
    chk("hold_grants", acc, n);
  endtask

  task automatic drain();
    int b = 0;
    while ((q.size() != 0 || busy) && b < 300) begin
      @(negedge PCLK);
      b++;
    end
    chk("drain_done", {31'd0, q.size() == 0}, 32'd1);
  endtask

  task automatic checkOutput(input string tag);
    chk({tag, "_req_ready"}, {30'd0, req_ready}, 32'd0);
    chk({tag, "_busy"}, {31'd0, busy}, 32'd0);
    chk({tag, "_csr_read"}, {31'd0, csr_read}, 32'd0);
    chk({tag, "_csr_write"}, {31'd0, csr_write}, 32'd0);
    chk({tag, "_csr_addr"}, {24'd0, csr_addr}, 32'd0);
    chk({tag, "_csr_wdata"}, csr_wdata, 32'd0);
    chk({tag, "_rsp_valid"}, {30'd0, rsp_valid}, 32'd0);
    chk({tag, "_rsp_rdata"}, rsp_rdata, 32'd0);
    chk({tag, "_rsp_error"}, {31'd0, rsp_error}, 32'd0);
  endtask

  task automatic reset_mid_issue(input int r);
    ready_delay = 0;
    applyStimulus(r, 1'b0, 8'h66, 32'h0);
    repeat (2) @(negedge PCLK);
    chk("mid_issue_busy", {31'd0, busy}, 32'd1);
    @(posedge PCLK); #1;
    PRESET = 1'b1;
    @(posedge PCLK); #1;
    PRESET = 1'b0;
    @(negedge PCLK);
    checkOutput("post_reset");
    ready_delay = 1;
    rdata_cfg   = 32'h0BAD_F00D;
    err_cfg     = 1'b0;
    expect_rsp(2'b01, 32'h0BAD_F00D, 1'b0, 1'b0, 8'h10, 32'h0, 1, 0);
    expect_rsp(2'b10, 32'h0BAD_F00D, 1'b0, 1'b0, 8'h21, 32'h0, 1, 3);
    hold_both(2, 2'b01);
    drain();
  endtask

  initial begin
    #200000;
    $display("[TB] FAIL watchdog: simulation did not finish, got timeout expected completion");
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    PRESET    = 1'b1;
    req_valid = 2'b11;
    req_write = 2'b00;
    req_addr  = 16'h0;
    req_wdata = 64'h0;

    // Reset state, with requests pending during reset
    repeat (3) @(posedge PCLK);
    @(negedge PCLK);
    checkOutput("reset");
    @(posedge PCLK); #1;
    PRESET    = 1'b0;
    req_valid = 2'b00;

    // Single read with two-cycle CSR latency
    ready_delay = 2; rdata_cfg = 32'hDEAD_BEEF; err_cfg = 1'b0;
    expect_rsp(2'b01, 32'hDEAD_BEEF, 1'b0, 1'b0, 8'h03, 32'h0, 2, 0);
    applyStimulus(0, 1'b0, 8'h03, 32'h0);
    drain();

    // Contention straight after reset: 0,1,0,1 every 3 cycles
    @(posedge PCLK); #1; PRESET = 1'b1;
    @(posedge PCLK); #1; PRESET = 1'b0;
    ready_delay = 1; rdata_cfg = 32'h1234_5678;
    expect_rsp(2'b01, 32'h1234_5678, 1'b0, 1'b0, 8'h10, 32'h0, 1, 0);
    expect_rsp(2'b10, 32'h1234_5678, 1'b0, 1'b0, 8'h21, 32'h0, 1, 3);
    expect_rsp(2'b01, 32'h1234_5678, 1'b0, 1'b0, 8'h10, 32'h0, 1, 3);
    expect_rsp(2'b10, 32'h1234_5678, 1'b0, 1'b0, 8'h21, 32'h0, 1, 3);
    hold_both(4, 2'b01);
    drain();

    // Write with CSR error: read data must be forced to zero
    ready_delay = 1; rdata_cfg = 32'hFFFF_FFFF; err_cfg = 1'b1;
    expect_rsp(2'b10, 32'h0, 1'b1, 1'b1, 8'h04, 32'h0000_00A5, 1, 0);
    applyStimulus(1, 1'b1, 8'h04, 32'h0000_00A5);
    drain();
    repeat (2) @(negedge PCLK);
    chk("hold_csr_wdata", csr_wdata, 32'h0000_00A5);
    chk("hold_csr_addr", {24'd0, csr_addr}, 32'h04);
    chk("hold_rsp_error", {31'd0, rsp_error}, 32'd1);
    chk("hold_csr_write", {31'd0, csr_write}, 32'd0);

    // Longer read latency from requester 0, then pointer sits at 1
    ready_delay = 3; rdata_cfg = 32'hCAFE_F00D; err_cfg = 1'b0;
    expect_rsp(2'b01, 32'hCAFE_F00D, 1'b0, 1'b0, 8'h7F, 32'h0, 3, 0);
    applyStimulus(0, 1'b0, 8'h7F, 32'h0);
    drain();

    // Both requesting with pointer at 1: requester 1 wins first
    ready_delay = 1; rdata_cfg = 32'h5A5A_0001;
    expect_rsp(2'b10, 32'h5A5A_0001, 1'b0, 1'b0, 8'h21, 32'h0, 1, 0);
    expect_rsp(2'b01, 32'h5A5A_0001, 1'b0, 1'b0, 8'h10, 32'h0, 1, 3);
    hold_both(2, 2'b10);
    drain();

`ifdef CSR_ARB_TIMEOUT_EN
    // Watchdog: slave never answers
    ready_delay = 0; rdata_cfg = 32'h7777_7777;
    expect_rsp(2'b01, 32'h0, 1'b1, 1'b0, 8'h55, 32'h0, 16, 0);
    applyStimulus(0, 1'b0, 8'h55, 32'h0);
    drain();
    @(negedge PCLK);
    chk("timeout_idle", {31'd0, busy}, 32'd0);
`endif

    // Reset during ISSUE drops the transaction and clears the pointer
    reset_mid_issue(1);
    reset_mid_issue(0);

    repeat (4) @(negedge PCLK);
    chk("queue_empty", q.size(), 32'd0);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
